// File: rtl/button_event_decoder.sv
// Push-button front end: 2-flop synchroniser, debounce, short/long press classifier and press counter.
// Optional auto-repeat of long_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 3000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             pressed,
  output logic             short_press,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  localparam int SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("button_event_decoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic          sync1, btn_s, btn_d;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt, hold_nx;
  state_t        state, state_nx;
  logic          short_nx, long_nx;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt, rep_nx;
`endif

  // btn_d delays btn_s by one cycle so a fresh change of the synchronised level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      btn_s    <= 1'b0;
      btn_d    <= 1'b0;
      stab_cnt <= '0;
      pressed  <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      btn_d <= btn_s;
      if (btn_s == pressed || btn_s != btn_d) begin
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        pressed  <= btn_s;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Release is tested before the long threshold so it wins when both happen together
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_nx   = rep_cnt;
`endif
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nx = PRESSED;
          hold_nx  = '0;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = HELD;
          long_nx  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_nx   = '0;
`endif
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      HELD: begin
`ifdef BTN_AUTOREPEAT_EN
        if (!pressed) begin
          state_nx = IDLE;
          rep_nx   = '0;
        end else if (rep_cnt == REP_LAST) begin
          rep_nx  = '0;
          long_nx = 1'b1;
        end else begin
          rep_nx = rep_cnt + 1'b1;
        end
`else
        if (!pressed) state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      press_count <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      short_press <= short_nx;
      long_press  <= long_nx;
      if (short_press || long_press) press_count <= press_count + CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= rep_nx;
`endif
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with small timing parameters (4/20/8, 3-bit counter).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_event_decoder;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       pressed;
  logic       short_press;
  logic       long_press;
  logic [2:0] press_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  int obs_short, obs_long, obs_short_k, obs_rise_k;
  int obs_long_k[4];
  bit obs_both;

  button_event_decoder #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(8),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .pressed(pressed),
    .short_press(short_press),
    .long_press(long_press),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k counts falling edges after btn goes high; btn drops right after observing edge k == hold
  task automatic do_press(input int hold, input int span);
    obs_short = 0; obs_long = 0; obs_short_k = 0; obs_rise_k = 0; obs_both = 0;
    for (int i = 0; i < 4; i++) obs_long_k[i] = 0;
    btn = 1'b1;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      if (pressed && obs_rise_k == 0) obs_rise_k = k;
      if (short_press && long_press) obs_both = 1'b1;
      if (short_press) begin
        obs_short++;
        if (obs_short_k == 0) obs_short_k = k;
      end
      if (long_press) begin
        if (obs_long < 4) obs_long_k[obs_long] = k;
        obs_long++;
      end
      if (k == hold) btn = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn = ~btn;
    end
    checks++;
    if ({pressed, short_press, long_press, press_count} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, expected 000000", {pressed, short_press, long_press, press_count});
    end
    btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_press(7, 30);
    exp_count = (exp_count + 1) % 8;
    checks++;
    if (obs_rise_k !== 7) begin
      errors++;
      $display("[TB] FAIL rise_latency: got %0d, expected 7", obs_rise_k);
    end
    checks++;
    if (obs_short_k !== 15) begin
      errors++;
      $display("[TB] FAIL reset_short_k: got %0d, expected 15", obs_short_k);
    end
    checks++;
    if (press_count !== 3'(exp_count)) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d, expected %0d", press_count, exp_count);
    end
  endtask

  task automatic test_bounce;
    bit saw = 1'b0;
    int pulses = 0;
    for (int k = 0; k < 24; k++) begin
      btn = (k < 4) ? ~k[0] : 1'b0;
      @(negedge clk);
      if (pressed) saw = 1'b1;
      if (short_press || long_press) pulses++;
    end
    checks++;
    if (saw !== 1'b0 || pulses !== 0) begin
      errors++;
      $display("[TB] FAIL bounce: got pressed_seen=%0d pulses=%0d, expected 0 0", saw, pulses);
    end
    do_press(4, 20);
    checks++;
    if (obs_rise_k !== 0 || obs_short !== 0 || obs_long !== 0) begin
      errors++;
      $display("[TB] FAIL glitch4: got rise=%0d short=%0d long=%0d, expected 0 0 0", obs_rise_k, obs_short, obs_long);
    end
    checks++;
    if (press_count !== 3'(exp_count)) begin
      errors++;
      $display("[TB] FAIL bounce_count: got %0d, expected %0d", press_count, exp_count);
    end
  endtask

  task automatic test_short;
    do_press(10, 40);
    exp_count = (exp_count + 1) % 8;
    checks++;
    if (obs_short !== 1 || obs_short_k !== 18 || obs_long !== 0 || obs_both !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short: got n=%0d k=%0d long=%0d both=%0d, expected 1 18 0 0", obs_short, obs_short_k, obs_long, obs_both);
    end
    checks++;
    if (press_count !== 3'(exp_count) || pressed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_count: got %0d/%0d, expected %0d/0", press_count, pressed, exp_count);
    end
  endtask

  task automatic test_long;
    do_press(40, 70);
`ifdef BTN_AUTOREPEAT_EN
    exp_count = (exp_count + 3) % 8;
    checks++;
    if (obs_long !== 3 || obs_long_k[0] !== 28 || obs_long_k[1] !== 36 || obs_long_k[2] !== 44) begin
      errors++;
      $display("[TB] FAIL long_repeat: got n=%0d k=%0d,%0d,%0d, expected 3 28,36,44", obs_long, obs_long_k[0], obs_long_k[1], obs_long_k[2]);
    end
`else
    exp_count = (exp_count + 1) % 8;
    checks++;
    if (obs_long !== 1 || obs_long_k[0] !== 28) begin
      errors++;
      $display("[TB] FAIL long: got n=%0d k=%0d, expected 1 28", obs_long, obs_long_k[0]);
    end
`endif
    checks++;
    if (obs_short !== 0 || obs_both !== 1'b0 || press_count !== 3'(exp_count)) begin
      errors++;
      $display("[TB] FAIL long_misc: got short=%0d both=%0d count=%0d, expected 0 0 %0d", obs_short, obs_both, press_count, exp_count);
    end
  endtask

  task automatic test_priority;
    do_press(20, 50);
    exp_count = (exp_count + 1) % 8;
    checks++;
    if (obs_short !== 1 || obs_short_k !== 28 || obs_long !== 0) begin
      errors++;
      $display("[TB] FAIL release_wins: got short=%0d k=%0d long=%0d, expected 1 28 0", obs_short, obs_short_k, obs_long);
    end
    do_press(21, 50);
    exp_count = (exp_count + 1) % 8;
    checks++;
    if (obs_long !== 1 || obs_long_k[0] !== 28 || obs_short !== 0) begin
      errors++;
      $display("[TB] FAIL long_edge: got long=%0d k=%0d short=%0d, expected 1 28 0", obs_long, obs_long_k[0], obs_short);
    end
    checks++;
    if (press_count !== 3'(exp_count)) begin
      errors++;
      $display("[TB] FAIL prio_count: got %0d, expected %0d", press_count, exp_count);
    end
  endtask

  task automatic test_wrap;
    int n;
    n = (7 - exp_count + 8) % 8;
    for (int i = 0; i < n; i++) do_press(6, 20);
    exp_count = 7;
    checks++;
    if (press_count !== 3'd7) begin
      errors++;
      $display("[TB] FAIL count_at_7: got %0d, expected 7", press_count);
    end
    do_press(6, 20);
    exp_count = 0;
    checks++;
    if (press_count !== 3'd0 || obs_short !== 1) begin
      errors++;
      $display("[TB] FAIL count_wrap: got %0d short=%0d, expected 0 1", press_count, obs_short);
    end
  endtask

  task automatic test_reset_mid_press;
    do_press(100, 19);
    checks++;
    if (obs_rise_k !== 7 || obs_short !== 0 || obs_long !== 0) begin
      errors++;
      $display("[TB] FAIL pre_reset: got rise=%0d short=%0d long=%0d, expected 7 0 0", obs_rise_k, obs_short, obs_long);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({pressed, short_press, long_press, press_count} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b, expected 000000", {pressed, short_press, long_press, press_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    do_press(28, 45);
    exp_count = 1;
    checks++;
    if (obs_rise_k !== 7) begin
      errors++;
      $display("[TB] FAIL midreset_rise: got %0d, expected 7", obs_rise_k);
    end
    checks++;
    if (obs_long !== 1 || obs_long_k[0] !== 28 || obs_short !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_long: got long=%0d k=%0d short=%0d, expected 1 28 0", obs_long, obs_long_k[0], obs_short);
    end
    checks++;
    if (press_count !== 3'(exp_count) || pressed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d/%0d, expected %0d/0", press_count, pressed, exp_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn = 1'b0;
    test_reset();
    test_bounce();
    test_short();
    test_long();
    test_priority();
    test_wrap();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
